// File: rtl/pulse_train_gen_pkg.sv
// rtl/pulse_train_gen_pkg.sv - shared FSM encodings and default widths for the pulse-train generator
package pulse_train_gen_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int WID_W_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// rtl/pulse_train_gen_phase_timer.sv - loadable down-counter timing one HIGH or LOW phase
module pulse_train_gen_phase_timer #(
  parameter int WID_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WID_W-1:0] load_value,
  output logic             expired
);

  logic [WID_W-1:0] value;

  // Loaded with width-1 so that a phase lasts load_value+1 cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - WID_W'(1);
    end
  end

  assign expired = (value == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - programmable pulse-train transmitter with edge counters and abort
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WID_W = WID_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic [WID_W-1:0] high_cycles,
  input  logic [WID_W-1:0] low_cycles,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pos_sent,
  output logic [CNT_W-1:0] neg_sent
);

  logic [1:0]       state;
  logic [CNT_W-1:0] pulses_left;
  logic [WID_W-1:0] h_m1;
  logic [WID_W-1:0] l_m1;
  logic [WID_W-1:0] high_m1_in;
  logic [WID_W-1:0] low_m1_in;
  logic             accept;
  logic             more;
  logic             expired;
  logic             timer_load;
  logic [WID_W-1:0] timer_value;

  // Widths are stored minus one; a programmed 0 behaves like 1.
  assign high_m1_in = (high_cycles == '0) ? '0 : high_cycles - WID_W'(1);
  assign low_m1_in  = (low_cycles  == '0) ? '0 : low_cycles  - WID_W'(1);
  assign accept     = start && (state == ST_IDLE || state == ST_DONE);
  assign more       = (pulses_left > CNT_W'(1));

  always_comb begin
    timer_load  = 1'b0;
    timer_value = h_m1;
    if (accept) begin
      timer_load  = (num_pulses != '0);
      timer_value = high_m1_in;
    end else if (!abort && expired) begin
      if (state == ST_HIGH) begin
        timer_load  = 1'b1;
        timer_value = l_m1;
      end else if (state == ST_LOW && more) begin
        timer_load  = 1'b1;
        timer_value = h_m1;
      end
    end
  end

  pulse_train_gen_phase_timer #(.WID_W(WID_W)) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pulse_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pos_sent    <= '0;
      neg_sent    <= '0;
      pulses_left <= '0;
      h_m1        <= '0;
      l_m1        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (start) begin
            h_m1        <= high_m1_in;
            l_m1        <= low_m1_in;
            pulses_left <= num_pulses;
            neg_sent    <= '0;
            if (num_pulses == '0) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              pos_sent <= '0;
            end else begin
              state     <= ST_HIGH;
              busy      <= 1'b1;
              pulse_out <= 1'b1;
              pos_sent  <= CNT_W'(1);
            end
          end
        end
        ST_HIGH: begin
          // Abort wins over phase expiry; the falling edge it causes still counts.
          if (abort || expired) begin
            pulse_out <= 1'b0;
            neg_sent  <= neg_sent + CNT_W'(1);
            state     <= abort ? ST_IDLE : ST_LOW;
            busy      <= !abort;
          end
        end
        default: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (expired) begin
            if (more) begin
              state       <= ST_HIGH;
              pulse_out   <= 1'b1;
              pos_sent    <= pos_sent + CNT_W'(1);
              pulses_left <= pulses_left - CNT_W'(1);
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
